// File: rtl/apb4_regbank_pkg.sv
// Shared types and helpers for the APB4 register bank.
// Phase encoding, index widths and response codes.
package apb4_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lane_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 0;
  endfunction

endpackage

// File: rtl/apb_reg_cell.sv
// One byte-strobed storage register of the bank.
// Cleared by the asynchronous bank reset.
module apb_reg_cell #(
  parameter int DATA_WIDTH = 32,
  parameter int NBYTES     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [NBYTES-1:0]     strb,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (strb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/apb4_regbank.sv
// APB4 slave with wait states, PSLVERR, RO status mapping
// and per-register write pulses.
module apb4_regbank
  import apb4_regbank_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NBYTES      = DATA_WIDTH / 8,
  parameter int NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic                           PSELx,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PWRITE,
  input  logic [NBYTES-1:0]              PSTRB,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic                           PENABLE,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int IDX_W  = idx_w(NUM_REGS);
  localparam int LANE_W = lane_w(NBYTES);
  localparam int AW1    = ADDR_WIDTH + 1;
  localparam int NSLOT  = 2 ** IDX_W;

  state_t state_q, state_d, phase;
  logic [3:0] cnt_q;
  logic wait_done, pready, err, commit;
  logic below, in_range, misalign;
  logic [AW1-1:0] off, off_idx;
  logic [IDX_W-1:0] idx;
  logic [NSLOT-1:0] ro_ext;
  logic [NUM_REGS-1:0] hit;
  logic [DATA_WIDTH-1:0] rd_sel;

  // Extra top bit keeps a PADDR below BASE_ADDR from aliasing.
  assign off      = {1'b0, PADDR} - {1'b0, BASE_ADDR};
  assign below    = off[ADDR_WIDTH];
  assign off_idx  = off >> LANE_W;
  assign in_range = !below && (off_idx < AW1'(NUM_REGS));
  assign misalign = (PADDR & ADDR_WIDTH'(NBYTES - 1)) != '0;
  assign idx      = off_idx[IDX_W-1:0];
  assign ro_ext   = NSLOT'(RO_MASK);

  assign err = !in_range || misalign
            || (in_range && PWRITE && ro_ext[idx]);

  assign wait_done = cnt_q == 4'(WAIT_STATES);
  assign pready    = (state_q == ACCESS) && PSELx
                  && PENABLE && wait_done;
  assign commit    = pready && PWRITE && !err;

  // A setup phase is recognised from the bus itself so the
  // following cycle can already be the completing access.
  always_comb begin
    phase   = state_q;
    state_d = state_q;
    if (state_q != ACCESS) begin
      phase = (PSELx && !PENABLE) ? SETUP : IDLE;
    end
    unique case (phase)
      IDLE:    state_d = IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (!(PSELx && PENABLE) || pready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ACCESS && state_d == ACCESS) begin
        if (!wait_done) cnt_q <= cnt_q + 4'd1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = commit && (idx == IDX_W'(i));
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) wr_pulse_o <= '0;
    else        wr_pulse_o <= hit;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_rw
      apb_reg_cell #(
        .DATA_WIDTH (DATA_WIDTH),
        .NBYTES     (NBYTES)
      ) u_cell (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (hit[i]),
        .strb  (PSTRB),
        .wdata (PWDATA),
        .q     (regs_o[i*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) begin
        rd_sel = RO_MASK[i]
               ? status_i[i*DATA_WIDTH +: DATA_WIDTH]
               : regs_o[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign PREADY  = pready;
  assign PSLVERR = (pready && err) ? RESP_ERR : RESP_OKAY;
  assign PRDATA  = (pready && !PWRITE && !err) ? rd_sel : '0;

endmodule

// File: tb/tb_apb4_regbank.sv
// Bench for apb4_regbank: two instances (0 and 3 wait states)
// checked against an address-level register model.
module tb_apb4_regbank;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [15:0] RO   = 16'h0003;

  logic PCLK = 1'b0;
  logic PRESET;
  logic psel0, psel3, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0] pstrb;
  logic [NR*DW-1:0] stat;

  logic [31:0] prdata0, prdata3;
  logic pready0, pready3, pslverr0, pslverr3;
  logic [NR*DW-1:0] regs0, regs3;
  logic [NR-1:0] pulse0, pulse3;

  int tests = 0;
  int fails = 0;
  logic [31:0] mdl [2][NR];
  logic [31:0] r_data;
  logic r_err;
  int r_cyc;
  logic [15:0] r_pulse;

  always #5 PCLK = ~PCLK;

  apb4_regbank #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NBYTES(4),
    .NUM_REGS(NR), .BASE_ADDR(BASE),
    .WAIT_STATES(0), .RO_MASK(RO)
  ) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSELx(psel0),
    .PADDR(paddr), .PWRITE(pwrite), .PSTRB(pstrb),
    .PWDATA(pwdata), .PENABLE(penable),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0),
    .status_i(stat), .regs_o(regs0), .wr_pulse_o(pulse0)
  );

  apb4_regbank #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NBYTES(4),
    .NUM_REGS(NR), .BASE_ADDR(BASE),
    .WAIT_STATES(3), .RO_MASK(RO)
  ) dut3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSELx(psel3),
    .PADDR(paddr), .PWRITE(pwrite), .PSTRB(pstrb),
    .PWDATA(pwdata), .PENABLE(penable),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3),
    .status_i(stat), .regs_o(regs3), .wr_pulse_o(pulse3)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input logic [31:0] a,
                                 input bit w);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off < 0) return 1'b1;
    if (off % 4 != 0) return 1'b1;
    if (off / 4 >= NR) return 1'b1;
    if (w && RO[int'(off / 4)]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  // Drives one transfer; returns data, error, length, pulse.
  task automatic xfer(input int d, input logic [31:0] a,
                      input bit w, input logic [3:0] s,
                      input logic [31:0] wd);
    bit got;
    int k;
    got = 1'b0;
    k = 0;
    paddr = a; pwrite = w; pstrb = s; pwdata = wd;
    penable = 1'b0;
    if (d == 0) psel0 = 1'b1; else psel3 = 1'b1;
    r_cyc = 1;
    r_data = '0;
    r_err = 1'b0;
    @(posedge PCLK); #1;
    penable = 1'b1;
    while (!got && k < 40) begin
      k++;
      r_cyc++;
      @(negedge PCLK);
      if ((d == 0 ? pready0 : pready3) === 1'b1) begin
        got = 1'b1;
        r_data = (d == 0) ? prdata0 : prdata3;
        r_err  = (d == 0) ? pslverr0 : pslverr3;
      end
      @(posedge PCLK); #1;
    end
    check("ready_seen", 32'(got), 32'd1);
    r_pulse = (d == 0) ? pulse0 : pulse3;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  task automatic op(input int d, input logic [31:0] a,
                    input bit w, input logic [3:0] s,
                    input logic [31:0] wd);
    bit e;
    int idx;
    logic [31:0] exp_rd;
    logic [15:0] exp_p;
    e = exp_err(a, w);
    idx = e ? 0 : int'((a - BASE) >> 2);
    xfer(d, a, w, s, wd);
    check($sformatf("cycles d%0d", d), 32'(r_cyc),
          32'(2 + (d == 0 ? 0 : 3)));
    check($sformatf("slverr a=%h", a), 32'(r_err), 32'(e));
    if (!w) begin
      if (e) exp_rd = '0;
      else if (RO[idx]) exp_rd = stat[idx*32 +: 32];
      else exp_rd = mdl[d][idx];
      check($sformatf("rdata a=%h", a), r_data, exp_rd);
    end
    exp_p = (w && !e) ? (16'd1 << idx) : 16'd0;
    check($sformatf("pulse a=%h", a), 32'(r_pulse),
          32'(exp_p));
    if (w && !e) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[d][idx][b*8 +: 8] = wd[b*8 +: 8];
      end
    end
  endtask

  task automatic check_regs(input int d);
    logic [31:0] got;
    for (int i = 0; i < NR; i++) begin
      got = (d == 0) ? regs0[i*32 +: 32] : regs3[i*32 +: 32];
      check($sformatf("regs d%0d r%0d", d, i), got,
            RO[i] ? 32'd0 : mdl[d][i]);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++) mdl[d][i] = '0;
  endtask

  initial begin
    logic [31:0] ra [8];
    logic [31:0] rv;
    PRESET = 1'b1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    for (int i = 0; i < NR; i++) stat[i*32 +: 32] = $urandom;
    stat[0 +: 32] = 32'hCAFE_0001;
    clear_model();

    #12;
    check("rst pready", 32'(pready0), 32'd0);
    check("rst pslverr", 32'(pslverr0), 32'd0);
    check("rst prdata", prdata0, 32'd0);
    check("rst pulse", 32'(pulse0), 32'd0);
    check("rst pready3", 32'(pready3), 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    check_regs(0);
    idle(1);

    // Full write then read, zero wait states
    op(0, BASE + 32'hC, 1'b1, 4'hF, 32'hDEAD_BEEF);
    idle(1);
    op(0, BASE + 32'hC, 1'b0, 4'h0, 32'h0);
    check("full word", r_data, 32'hDEAD_BEEF);

    // Partial strobes and pulse width
    op(0, BASE + 32'hC, 1'b1, 4'b0101, 32'h1122_3344);
    idle(1);
    check("pulse gone", 32'(pulse0), 32'd0);
    op(0, BASE + 32'hC, 1'b0, 4'hF, 32'h0);
    check("merge", r_data, 32'hDE22_BE44);

    // Same on the three-wait-state instance
    op(1, BASE + 32'hC, 1'b1, 4'hF, 32'hDEAD_BEEF);
    op(1, BASE + 32'hC, 1'b1, 4'b0101, 32'h1122_3344);
    op(1, BASE + 32'hC, 1'b0, 4'hF, 32'h0);
    check("merge ws3", r_data, 32'hDE22_BE44);

    // Error responses and RO reads
    for (int d = 0; d < 2; d++) begin
      op(d, BASE + 32'h40, 1'b1, 4'hF, $urandom);
      op(d, BASE + 32'h2, 1'b0, 4'hF, 32'h0);
      op(d, BASE + 32'h2, 1'b1, 4'hF, $urandom);
      op(d, BASE + 32'h4, 1'b1, 4'hF, $urandom);
      op(d, BASE - 32'h4, 1'b0, 4'hF, 32'h0);
      op(d, BASE - 32'h4, 1'b1, 4'hF, $urandom);
      op(d, BASE, 1'b0, 4'hF, 32'h0);
      check($sformatf("ro status d%0d", d), r_data,
            32'hCAFE_0001);
      op(d, BASE + 32'h8, 1'b1, 4'h0, $urandom);
      op(d, BASE + 32'h8, 1'b0, 4'hF, 32'h0);
      check_regs(d);
    end

    // Abort during first wait cycle of a write
    paddr = BASE + 32'h14; pwrite = 1'b1; pstrb = 4'hF;
    pwdata = 32'h5555_AAAA; psel3 = 1'b1; penable = 1'b0;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    check("abort no ready", 32'(pready3), 32'd0);
    psel3 = 1'b0; penable = 1'b0;
    idle(2);
    check("abort pulse", 32'(pulse3), 32'd0);
    check("abort reg", regs3[5*32 +: 32], mdl[1][5]);
    op(1, BASE + 32'h14, 1'b0, 4'hF, 32'h0);

    // Reset in the middle of an access
    paddr = BASE + 32'h18; pwrite = 1'b1; pstrb = 4'hF;
    pwdata = 32'h1234_5678; psel3 = 1'b1; penable = 1'b0;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    #1;
    check("rst mid pready", 32'(pready3), 32'd0);
    check("rst mid r3", regs3[3*32 +: 32], 32'd0);
    check("rst mid d0 r3", regs0[3*32 +: 32], 32'd0);
    clear_model();
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      check("post rst pready", 32'(pready3), 32'd0);
    end
    @(posedge PCLK); #1;
    psel3 = 1'b0; penable = 1'b0;
    check_regs(1);
    op(1, BASE + 32'h18, 1'b0, 4'hF, 32'h0);

    // Back-to-back random writes then reads
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin
        ra[k] = BASE + 32'($urandom_range(2, NR - 1) * 4);
        op(d, ra[k], 1'b1, 4'($urandom_range(0, 15)),
           $urandom);
      end
      for (int k = 0; k < 8; k++) begin
        op(d, ra[k], 1'b0, 4'($urandom_range(0, 15)), 32'h0);
      end
      idle(1);
    end

    // Random mix including illegal addresses
    for (int k = 0; k < 30; k++) begin
      rv = BASE - 32'h8 + 32'($urandom_range(0, 32'h50));
      if ($urandom_range(0, 3) != 0) rv = rv & ~32'h3;
      op(k % 2, rv, 1'($urandom_range(0, 1)),
         4'($urandom_range(0, 15)), $urandom);
    end
    idle(1);
    check_regs(0);
    check_regs(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
